spi_master: RTL and testbench

Single-slave SPI bus master that generates `spi_clk`, `chip_select` and `MOSI` from the system clock and captures `MISO`. It transfers one `data_width`-bit word per request, MSB first, full-duplex. It is the initiator counterpart to the SPI slave and shares that block's parameter set. Any CPOL/CPHA combination on both ends interoperates when the parameters match.

---
 rtl/spi_master.sv | 203 ++++++++++++++++++++
 tb/tb_spi_master.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
`timescale 1ns/1ps
// spi_master
// Single-slave SPI bus master. Sends one data_width-bit word per request,
// MSB first, full duplex, with selectable clock polarity (CPOL) and phase
// (CPHA). Every output is registered; all logic runs on the rising edge of clk.
//
// Frame sequence, with H = clk cycles per SCLK half period:
//   IDLE -> LEAD (H cycles, chip_select low) -> XFER (2*data_width SCLK edges,
//   H cycles apart) -> TRAIL (H cycles) -> GAP (H cycles, chip_select high)
//   -> IDLE
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   start        in   transfer request, sampled only in IDLE
//   data_in      in   word to send, latched when start is accepted
//   busy         out  high from the cycle after acceptance until back in IDLE
//   data_valid   out  one-cycle pulse when data_out holds a new word
//   data_out     out  last received word
//   spi_clk      out  SPI clock, idles at CPOL
//   chip_select  out  active-low slave select
//   MOSI         out  serial data to slave, 0 whenever chip_select is high
//   MISO         in   serial data from slave (the slave is clocked by clk,
//                     so MISO is treated as synchronous)
module spi_master #(
    parameter int system_clk_frequency = 50_000_000,
    parameter int spi_clk_frequency    = 5_000_000,
    parameter int data_width           = 8,
    parameter bit CPOL                 = 1'b1,
    parameter bit CPHA                 = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [data_width-1:0] data_in,
    output logic                  busy,
    output logic                  data_valid,
    output logic [data_width-1:0] data_out,
    output logic                  spi_clk,
    output logic                  chip_select,
    output logic                  MOSI,
    input  logic                  MISO
);

    localparam int H      = system_clk_frequency / (2 * spi_clk_frequency);
    localparam int CNT_W  = (H > 1) ? $clog2(H) : 1;
    localparam int EDGE_W = $clog2(2 * data_width);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(H - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * data_width - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL,
        GAP
    } state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [EDGE_W-1:0]       edge_cnt_reg, edge_cnt_next;
    logic                    sclk_reg, sclk_next;
    logic                    cs_reg, cs_next;
    logic                    mosi_reg, mosi_next;
    logic [data_width-1:0]   tx_reg, tx_next;
    logic [data_width-1:0]   rx_reg, rx_next;
    logic [data_width-1:0]   data_out_reg, data_out_next;
    logic                    busy_reg, busy_next;
    logic                    dv_reg, dv_next;

    logic                    tick;
    logic                    sclk_edge;
    logic                    edge_even;

    // End of the current H-cycle interval.
    assign tick      = (cnt_reg == CNT_LAST);
    // Even edge index = leading edge, odd = trailing edge.
    assign edge_even = ~edge_cnt_reg[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            edge_cnt_reg <= '0;
            sclk_reg     <= CPOL;
            cs_reg       <= 1'b1;
            mosi_reg     <= 1'b0;
            tx_reg       <= '0;
            rx_reg       <= '0;
            data_out_reg <= '0;
            busy_reg     <= 1'b0;
            dv_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            edge_cnt_reg <= edge_cnt_next;
            sclk_reg     <= sclk_next;
            cs_reg       <= cs_next;
            mosi_reg     <= mosi_next;
            tx_reg       <= tx_next;
            rx_reg       <= rx_next;
            data_out_reg <= data_out_next;
            busy_reg     <= busy_next;
            dv_reg       <= dv_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        edge_cnt_next = edge_cnt_reg;
        sclk_next     = sclk_reg;
        cs_next       = cs_reg;
        mosi_next     = mosi_reg;
        tx_next       = tx_reg;
        rx_next       = rx_reg;
        data_out_next = data_out_reg;
        busy_next     = busy_reg;
        dv_next       = 1'b0;
        sclk_edge     = 1'b0;

        // One free-running interval counter serves every timed state.
        if (state_reg != IDLE) begin
            cnt_next = tick ? '0 : cnt_reg + CNT_W'(1);
        end

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (start) begin
                    state_next    = LEAD;
                    cs_next       = 1'b0;
                    busy_next     = 1'b1;
                    edge_cnt_next = '0;
                    tx_next       = data_in;
                    // CPHA=0 needs the MSB valid before the first edge.
                    mosi_next     = CPHA ? 1'b0 : data_in[data_width-1];
                end
            end
            LEAD: begin
                if (tick) begin
                    sclk_edge  = 1'b1;
                    state_next = XFER;
                end
            end
            XFER: begin
                if (tick) begin
                    sclk_edge = 1'b1;
                    if (edge_cnt_reg == EDGE_LAST) begin
                        state_next = TRAIL;
                    end
                end
            end
            TRAIL: begin
                if (tick) begin
                    cs_next       = 1'b1;
                    mosi_next     = 1'b0;
                    dv_next       = 1'b1;
                    data_out_next = rx_reg;
                    state_next    = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // SCLK edge handling. MISO is captured on the same clk edge that
        // registers the new spi_clk level, i.e. it sees the value the slave
        // has been presenting for the preceding half period.
        if (sclk_edge) begin
            sclk_next     = ~sclk_reg;
            edge_cnt_next = edge_cnt_reg + EDGE_W'(1);
            if (edge_even != CPHA) begin
                rx_next = {rx_reg[data_width-2:0], MISO};
            end
            if (!CPHA && !edge_even && (edge_cnt_reg != EDGE_LAST)) begin
                // MSB already went out at chip_select fall; advance one bit.
                mosi_next = tx_reg[data_width-2];
                tx_next   = tx_reg << 1;
            end
            if (CPHA && edge_even) begin
                mosi_next = tx_reg[data_width-1];
                tx_next   = tx_reg << 1;
            end
        end
    end

    assign busy        = busy_reg;
    assign data_valid  = dv_reg;
    assign data_out    = data_out_reg;
    assign spi_clk     = sclk_reg;
    assign chip_select = cs_reg;
    assign MOSI        = mosi_reg;

endmodule

// File: tb/tb_spi_master.sv
`timescale 1ns/1ps
// tb_spi_master
// Directed bench for spi_master. u_dut uses the default mode 3 parameters,
// u_dut0 runs mode 0. Each master talks to a small behavioural SPI slave
// written inline; expected values are hand-computed constants.
module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    // mode 3 instance
    logic       start, busy, dv, sclk, cs, mosi, miso;
    logic [7:0] data_in, dout;
    // mode 0 instance
    logic       start0, busy0, dv0, sclk0, cs0, mosi0, miso0;
    logic [7:0] din0, dout0;

    spi_master u_dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .busy(busy), .data_valid(dv), .data_out(dout),
        .spi_clk(sclk), .chip_select(cs), .MOSI(mosi), .MISO(miso)
    );

    spi_master #(.CPOL(1'b0), .CPHA(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .data_in(din0),
        .busy(busy0), .data_valid(dv0), .data_out(dout0),
        .spi_clk(sclk0), .chip_select(cs0), .MOSI(mosi0), .MISO(miso0)
    );

    // mode 3 slave: drive on falling (leading) edge, sample on rising
    logic [7:0] s_word, s_tx, s_rx;
    always @(negedge cs) begin
        s_tx = s_word;
        s_rx = 8'h00;
    end
    always @(negedge sclk) if (cs === 1'b0) begin
        miso = s_tx[7];
        s_tx = s_tx << 1;
    end
    always @(posedge sclk) if (cs === 1'b0) s_rx = {s_rx[6:0], mosi};

    // mode 0 slave: MSB at select, sample on rising, shift on falling
    logic [7:0] s0_word, s0_tx, s0_rx;
    always @(negedge cs0) begin
        s0_tx = s0_word;
        s0_rx = 8'h00;
        miso0 = s0_tx[7];
        s0_tx = s0_tx << 1;
    end
    always @(posedge sclk0) if (cs0 === 1'b0) s0_rx = {s0_rx[6:0], mosi0};
    always @(negedge sclk0) if (cs0 === 1'b0) begin
        miso0 = s0_tx[7];
        s0_tx = s0_tx << 1;
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // observation results (mode 3 instance), n counts cycles from t0
    int         toggles, first_t, last_t, bad_sp, busy_cyc, dv_n, cs_rise;
    int         min_run, mosi_ones;
    int         dv_t [4];
    logic [7:0] dv_rx [4];
    logic [7:0] dv_out [4];
    logic       mosi_t0, cs_t0, busy_t0;

    // Request a transfer and step to t0 (first cycle after acceptance).
    task automatic launch(input logic [7:0] m, input logic [7:0] s);
        s_word  = s;
        data_in = m;
        start   = 1'b1;
        @(negedge clk);
    endtask

    // Watch u_dut for ncyc cycles starting at the current negedge (n = 0).
    // release_at: cycle where start drops and data_in becomes rel_data.
    // inject_at: cycle where a one-cycle 0xFF request is attempted.
    task automatic observe(input int ncyc, input int release_at, input int inject_at,
                           input logic [7:0] rel_data);
        logic prev_sclk, prev_cs, saw_low;
        int   run;
        toggles = 0; first_t = -1; last_t = -1; bad_sp = 0; busy_cyc = 0;
        dv_n = 0; cs_rise = -1; min_run = 1000; mosi_ones = 0;
        for (int i = 0; i < 4; i++) begin
            dv_t[i] = -1; dv_rx[i] = 8'h00; dv_out[i] = 8'h00;
        end
        mosi_t0 = mosi; cs_t0 = cs; busy_t0 = busy;
        prev_sclk = 1'b1;
        prev_cs   = cs;
        saw_low   = 1'b0;
        run       = 0;
        for (int n = 0; n < ncyc; n++) begin
            if (sclk !== prev_sclk) begin
                toggles++;
                if (first_t < 0) first_t = n;
                last_t = n;
                if (n % 5 != 0) bad_sp++;
            end
            if (busy === 1'b1) busy_cyc++;
            if (dv === 1'b1) begin
                if (dv_n < 4) begin
                    dv_t[dv_n]   = n;
                    dv_rx[dv_n]  = s_rx;
                    dv_out[dv_n] = dout;
                end
                dv_n++;
            end
            if (cs === 1'b1 && prev_cs === 1'b0 && cs_rise < 0) cs_rise = n;
            if (cs === 1'b1) begin
                run++;
            end else begin
                if (saw_low && run > 0 && run < min_run) min_run = run;
                run     = 0;
                saw_low = 1'b1;
            end
            if (mosi === 1'b1) mosi_ones++;
            prev_sclk = sclk;
            prev_cs   = cs;
            if (n == release_at) begin
                start   = 1'b0;
                data_in = rel_data;
            end
            if (n == inject_at) begin
                start   = 1'b1;
                data_in = 8'hFF;
            end
            if (inject_at >= 0 && n == inject_at + 1) begin
                start   = 1'b0;
                data_in = 8'h00;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        start = 1'b0; data_in = 8'h00; miso = 1'b0; s_word = 8'h00;
        start0 = 1'b0; din0 = 8'h00; miso0 = 1'b0; s0_word = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        check("rst_sclk", 32'(sclk), 32'(1'b1));
        check("rst_cs", 32'(cs), 32'(1'b1));
        check("rst_mosi", 32'(mosi), 32'(1'b0));
        check("rst_busy", 32'(busy), 32'(1'b0));
        check("rst_dv", 32'(dv), 32'(1'b0));
        check("rst_dout", 32'(dout), 32'(8'h00));
        check("rst_sclk_mode0", 32'(sclk0), 32'(1'b0));

        // mode 3 frame: send A5, slave answers 3C; data_in changed after accept
        launch(8'hA5, 8'h3C);
        observe(100, 0, -1, 8'h00);
        check("m3_cs_t0", 32'(cs_t0), 32'(1'b0));
        check("m3_busy_t0", 32'(busy_t0), 32'(1'b1));
        check("m3_mosi_t0", 32'(mosi_t0), 32'(1'b0));
        check("m3_toggles", 32'(toggles), 32'(16));
        check("m3_first_edge", 32'(first_t), 32'(5));
        check("m3_last_edge", 32'(last_t), 32'(80));
        check("m3_edge_spacing", 32'(bad_sp), 32'(0));
        check("m3_busy_cycles", 32'(busy_cyc), 32'(90));
        check("m3_dv_count", 32'(dv_n), 32'(1));
        check("m3_dv_time", 32'(dv_t[0]), 32'(85));
        check("m3_cs_rise", 32'(cs_rise), 32'(85));
        check("m3_master_rx", 32'(dv_out[0]), 32'(8'h3C));
        check("m3_slave_rx", 32'(dv_rx[0]), 32'(8'hA5));
        check("m3_sclk_idle", 32'(sclk), 32'(1'b1));

        // start pulse mid-transfer is ignored
        launch(8'h00, 8'h96);
        observe(200, 0, 20, 8'h00);
        check("ign_mosi_ones", 32'(mosi_ones), 32'(0));
        check("ign_dv_count", 32'(dv_n), 32'(1));
        check("ign_master_rx", 32'(dv_out[0]), 32'(8'h96));
        check("ign_slave_rx", 32'(dv_rx[0]), 32'(8'h00));

        // reset at t0+40 aborts the frame
        launch(8'hA5, 8'h3C);
        start = 1'b0;
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_cs", 32'(cs), 32'(1'b1));
        check("abort_sclk", 32'(sclk), 32'(1'b1));
        check("abort_busy", 32'(busy), 32'(1'b0));
        check("abort_dout", 32'(dout), 32'(8'h00));
        check("abort_dv", 32'(dv), 32'(1'b0));
        rst = 1'b0;
        observe(120, -1, -1, 8'h00);
        check("abort_no_dv", 32'(dv_n), 32'(0));
        check("abort_no_edges", 32'(toggles), 32'(0));
        launch(8'hC3, 8'h5A);
        observe(100, 0, -1, 8'h00);
        check("after_master_rx", 32'(dv_out[0]), 32'(8'h5A));
        check("after_slave_rx", 32'(dv_rx[0]), 32'(8'hC3));
        check("after_dv_time", 32'(dv_t[0]), 32'(85));

        // start held: three back-to-back frames of 0x55
        launch(8'h55, 8'hAA);
        observe(300, 183, -1, 8'h55);
        check("held_dv_count", 32'(dv_n), 32'(3));
        check("held_dv0", 32'(dv_t[0]), 32'(85));
        check("held_gap01", 32'(dv_t[1] - dv_t[0]), 32'(91));
        check("held_gap12", 32'(dv_t[2] - dv_t[1]), 32'(91));
        check("held_cs_high", 32'(min_run), 32'(6));
        for (int i = 0; i < 3; i++) begin
            check($sformatf("held_slave_rx%0d", i), 32'(dv_rx[i]), 32'(8'h55));
            check($sformatf("held_master_rx%0d", i), 32'(dv_out[i]), 32'(8'hAA));
        end

        // mode 0 frame: send 81, slave answers 7E
        s0_word = 8'h7E;
        din0    = 8'h81;
        start0  = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        din0   = 8'h00;
        check("m0_mosi_t0", 32'(mosi0), 32'(1'b1));
        check("m0_cs_t0", 32'(cs0), 32'(1'b0));
        check("m0_busy_t0", 32'(busy0), 32'(1'b1));
        w = 0;
        while (dv0 !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("m0_dv_time", 32'(w), 32'(85));
        check("m0_master_rx", 32'(dout0), 32'(8'h7E));
        check("m0_slave_rx", 32'(s0_rx), 32'(8'h81));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
